// File: rtl/dsp_mac_seq.sv
// -----------------------------------------------------------------------------
// dsp_mac_seq
//   Sequencer that runs one DSP48A1-style slice as a multiply-accumulator.
//   A job of `len` operand pairs arrives on a valid/ready stream. The block
//   drives the slice's A/B operands, OPMODE and CE/RST controls, and follows
//   each accepted pair through the slice pipeline. When the last pair has
//   reached the P register, the block captures the 48-bit P value and reports
//   it with a one-cycle result_valid/done pulse.
//
//   Optional feature (compile-time macro DSP_MAC_ABORT_EN):
//     adds an `abort` input. Abort in LOAD or DRAIN returns the block to IDLE,
//     pulses done without result_valid, leaves result unchanged and pulses
//     dsp_rstp for one cycle to clear the slice accumulator.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   abort             (DSP_MAC_ABORT_EN only) cancels a running job
//   start, len        job request and pair count, sampled only in IDLE
//   busy, done        job in progress / one-cycle end-of-job pulse
//   s_valid, s_ready  operand stream handshake
//   s_a, s_b          operand pair
//   dsp_a, dsp_b      registered operands to the slice
//   dsp_opmode        slice OPMODE, aligned with the P-register update
//   dsp_ce_ab         A/B register enable (one cycle after each accepted pair)
//   dsp_ce_mp         M/P register enable (high while busy)
//   dsp_rstp          P register reset
//   dsp_p             slice P output
//   result            final accumulation, held until the next done
//   result_valid      one-cycle pulse with done for a completed job
// -----------------------------------------------------------------------------
module dsp_mac_seq #(
    parameter int N        = 18,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DSP_MAC_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_a,
    input  logic [N-1:0]     s_b,
    output logic [N-1:0]     dsp_a,
    output logic [N-1:0]     dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce_ab,
    output logic             dsp_ce_mp,
    output logic             dsp_rstp,
    input  logic [47:0]      dsp_p,
    output logic [47:0]      result,
    output logic             result_valid
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Slice OPMODE values
    localparam logic [7:0] OPM_OFF   = 8'h00;  // X=0, Z=0
    localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0: restart accumulation
    localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P: accumulate
    localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P: bubble, keep P

    // The tracker holds PIPE_LAT-1 {valid, first} stages; the registered
    // OPMODE output is its final stage, so the total depth is PIPE_LAT.
    localparam int TRK_D   = PIPE_LAT - 1;
    localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

    localparam logic [LEN_W-1:0]   LEN_ZERO   = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]   LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_LAT);

    // Map a beat descriptor arriving at the P stage onto the slice OPMODE.
    function automatic logic [7:0] opmode_enc(input logic valid, input logic first);
        logic [7:0] op;
        if (!valid) begin
            op = OPM_HOLD;
        end else if (first) begin
            op = OPM_FIRST;
        end else begin
            op = OPM_ACC;
        end
        return op;
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [LEN_W-1:0]   cnt_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic               first_pend_r;
    logic               busy_r;
    logic               done_r;
    logic               s_ready_r;
    logic               result_valid_r;
    logic               ce_ab_r;
    logic               rstp_r;
    logic [N-1:0]       dsp_a_r;
    logic [N-1:0]       dsp_b_r;
    logic [7:0]         opmode_r;
    logic [47:0]        result_r;
    logic [TRK_D-1:0]   trk_valid_r;
    logic [TRK_D-1:0]   trk_first_r;
    logic               beat_s;
    logic               abort_s;
    logic               run_nxt_s;

    // s_ready_r is high exactly while in LOAD, so it qualifies the handshake.
    assign beat_s = s_valid & s_ready_r;

`ifdef DSP_MAC_ABORT_EN
    assign abort_s = abort & ((state_r == ST_LOAD) | (state_r == ST_DRAIN));
`else
    assign abort_s = 1'b0;
`endif

    assign run_nxt_s = (state_nxt_s == ST_LOAD) | (state_nxt_s == ST_DRAIN);

    // Next-state logic for the job sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len == LEN_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (beat_s && (cnt_r == LEN_ONE)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (drain_cnt_r == DRAIN_ZERO) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, handshake/status outputs and job counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            s_ready_r      <= 1'b0;
            result_valid_r <= 1'b0;
            ce_ab_r        <= 1'b0;
            rstp_r         <= 1'b0;
            cnt_r          <= LEN_ZERO;
            drain_cnt_r    <= DRAIN_ZERO;
            first_pend_r   <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            busy_r         <= (state_nxt_s != ST_IDLE);
            s_ready_r      <= (state_nxt_s == ST_LOAD);
            done_r         <= (state_nxt_s == ST_DONE) | abort_s;
            result_valid_r <= (state_nxt_s == ST_DONE);
            ce_ab_r        <= beat_s;
            rstp_r         <= abort_s;

            if ((state_r == ST_IDLE) && start) begin
                cnt_r <= len;
            end else if (beat_s) begin
                cnt_r <= cnt_r - LEN_ONE;
            end else begin
                cnt_r <= cnt_r;
            end

            // The extra DRAIN cycle lets P settle before it is captured.
            if ((state_r == ST_LOAD) && (state_nxt_s == ST_DRAIN)) begin
                drain_cnt_r <= DRAIN_INIT;
            end else if ((state_r == ST_DRAIN) && (drain_cnt_r != DRAIN_ZERO)) begin
                drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
            end else begin
                drain_cnt_r <= drain_cnt_r;
            end

            if ((state_r == ST_IDLE) && (state_nxt_s == ST_LOAD)) begin
                first_pend_r <= 1'b1;
            end else if (beat_s || abort_s) begin
                first_pend_r <= 1'b0;
            end else begin
                first_pend_r <= first_pend_r;
            end
        end
    end

    // Operand registers feeding the slice A/B inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsp_a_r <= {N{1'b0}};
            dsp_b_r <= {N{1'b0}};
        end else if (beat_s) begin
            dsp_a_r <= s_a;
            dsp_b_r <= s_b;
        end else begin
            dsp_a_r <= dsp_a_r;
            dsp_b_r <= dsp_b_r;
        end
    end

    // Beat tracker: follows each cycle's {valid, first} down the slice
    // pipeline and turns it into the OPMODE for the P-stage cycle.
    always_ff @(posedge clk) begin
        if (rst || abort_s) begin
            trk_valid_r <= {TRK_D{1'b0}};
            trk_first_r <= {TRK_D{1'b0}};
            opmode_r    <= OPM_OFF;
        end else begin
            trk_valid_r[0] <= beat_s;
            trk_first_r[0] <= beat_s & first_pend_r;
            for (int i = 1; i < TRK_D; i++) begin
                trk_valid_r[i] <= trk_valid_r[i-1];
                trk_first_r[i] <= trk_first_r[i-1];
            end
            if (run_nxt_s) begin
                opmode_r <= opmode_enc(trk_valid_r[TRK_D-1], trk_first_r[TRK_D-1]);
            end else begin
                opmode_r <= OPM_OFF;
            end
        end
    end

    // Result capture as the job enters DONE; a zero-length job reports 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= 48'h0;
        end else if (state_nxt_s == ST_DONE) begin
            if (state_r == ST_IDLE) begin
                result_r <= 48'h0;
            end else begin
                result_r <= dsp_p;
            end
        end else begin
            result_r <= result_r;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign s_ready      = s_ready_r;
    assign result_valid = result_valid_r;
    assign dsp_a        = dsp_a_r;
    assign dsp_b        = dsp_b_r;
    assign dsp_opmode   = opmode_r;
    assign dsp_ce_ab    = ce_ab_r;
    assign dsp_ce_mp    = busy_r;
    // P is cleared for as long as rst is held, plus the one-cycle abort pulse.
    assign dsp_rstp     = rst | rstp_r;
    assign result       = result_r;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_dsp_mac_seq
//   Self-checking bench for dsp_mac_seq. A behavioural DSP48A1-style slice
//   (A/B reg, M reg, P reg) closes the loop. Expected job results are pushed
//   into a scoreboard when a job is issued; a monitor pops and compares them
//   whenever done is presented.
// -----------------------------------------------------------------------------
module tb_dsp_mac_seq;
    localparam int N        = 18;
    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy, done, s_valid, s_ready;
    logic [N-1:0]     s_a, s_b, dsp_a, dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_ce_ab, dsp_ce_mp, dsp_rstp, result_valid;
    logic [47:0]      dsp_p, result;
`ifdef DSP_MAC_ABORT_EN
    logic             abort;
`endif

    int checks   = 0;
    int failures = 0;

    // Observation counters, cleared by the stimulus before a job.
    int busy_cyc  = 0;
    int ce_ab_cyc = 0;
    int n01 = 0, n08 = 0, n09 = 0;

    logic [47:0] exp_res_q[$];
    logic        exp_rv_q[$];

    logic signed [N-1:0] va [0:7];
    logic signed [N-1:0] vb [0:7];

    always #5 clk = ~clk;

    dsp_mac_seq #(.N(N), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef DSP_MAC_ABORT_EN
        .abort        (abort),
`endif
        .start        (start),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_opmode   (dsp_opmode),
        .dsp_ce_ab    (dsp_ce_ab),
        .dsp_ce_mp    (dsp_ce_mp),
        .dsp_rstp     (dsp_rstp),
        .dsp_p        (dsp_p),
        .result       (result),
        .result_valid (result_valid)
    );

    // Behavioural slice: A/B reg -> M reg (signed product) -> P reg.
    logic signed [N-1:0]   a_q = '0;
    logic signed [N-1:0]   b_q = '0;
    logic signed [2*N-1:0] prod;
    logic [47:0]           m_q = '0;
    logic [47:0]           p_q = '0;
    assign prod  = a_q * b_q;
    assign dsp_p = p_q;

    always @(posedge clk) begin
        if (dsp_ce_ab) begin
            a_q <= dsp_a;
            b_q <= dsp_b;
        end
        if (dsp_ce_mp) m_q <= {{(48-2*N){prod[2*N-1]}}, prod};
        if (dsp_rstp) begin
            p_q <= '0;
        end else if (dsp_ce_mp) begin
            case (dsp_opmode)
                8'h01:   p_q <= m_q;
                8'h09:   p_q <= p_q + m_q;
                8'h08:   p_q <= p_q;
                default: p_q <= '0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: counts observations and checks each done against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cyc++;
            if (dsp_ce_ab) ce_ab_cyc++;
            case (dsp_opmode)
                8'h01:   n01++;
                8'h08:   n08++;
                8'h09:   n09++;
                default: ;
            endcase
            if (done) begin
                if (exp_res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    chk("sb_result_valid", 64'(result_valid), 64'(exp_rv_q.pop_front()));
                    chk("sb_result", 64'(result), 64'(exp_res_q.pop_front()));
                end
            end else if (result_valid) begin
                checks++;
                failures++;
                $display("FAIL result_valid_without_done actual=1 expected=0");
            end
        end
    end

    task automatic clear_counts();
        busy_cyc = 0; ce_ab_cyc = 0; n01 = 0; n08 = 0; n09 = 0;
    endtask

    task automatic start_job(input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beats(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            s_a = va[i];
            s_b = vb[i];
            s_valid = 1'b1;
            for (int w = 0; w < 50 && !s_ready; w++) begin
                @(posedge clk); #1;
            end
            if (!s_ready) chk("s_ready_timeout", 64'(s_ready), 64'd1);
            @(posedge clk); #1;
            if (gap > 0) begin
                s_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int w = 0; w < 100 && !done; w++) begin
            @(posedge clk); #1;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic expect_job(input logic [47:0] res, input logic rv);
        exp_res_q.push_back(res);
        exp_rv_q.push_back(rv);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_a = '0; s_b = '0;
`ifdef DSP_MAC_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_ce_ab", 64'(dsp_ce_ab), 64'd0);
        chk("rst_ce_mp", 64'(dsp_ce_mp), 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_dsp_a", 64'(dsp_a), 64'd0);
        chk("rst_dsp_b", 64'(dsp_b), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_opmode", 64'(dsp_opmode), 64'h00);
        chk("rst_rstp_high", 64'(dsp_rstp), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_rstp_low", 64'(dsp_rstp), 64'd0);

        // T1: 1*2 + 3*4 + (-5)*6 + 7*(-8) = 2 + 12 - 30 - 56 = -72
        va[0] = 18'sd1;  vb[0] = 18'sd2;
        va[1] = 18'sd3;  vb[1] = 18'sd4;
        va[2] = -18'sd5; vb[2] = 18'sd6;
        va[3] = 18'sd7;  vb[3] = -18'sd8;
        clear_counts();
        expect_job(48'hFFFF_FFFF_FFB8, 1'b1);
        start_job(8'd4);
        send_beats(4, 0);
        wait_done();
        @(posedge clk); #1;
        chk("t1_busy_cycles", 64'(busy_cyc), 64'(4 + PIPE_LAT + 2));
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_op01", 64'(n01), 64'd1);
        chk("t1_op09", 64'(n09), 64'd3);
        chk("t1_op08", 64'(n08), 64'd4);
        chk("t1_ce_ab_cycles", 64'(ce_ab_cyc), 64'd4);

        // T2: (100,100) x3 with two bubble cycles between beats -> 30000
        for (int i = 0; i < 3; i++) begin
            va[i] = 18'sd100; vb[i] = 18'sd100;
        end
        clear_counts();
        expect_job(48'd30000, 1'b1);
        start_job(8'd3);
        send_beats(3, 2);
        wait_done();
        @(posedge clk); #1;
        chk("t2_op01", 64'(n01), 64'd1);
        chk("t2_op09", 64'(n09), 64'd2);
        chk("t2_op08_bubbles", 64'(n08), 64'd8);

        // T3: zero-length job -> immediate done with result 0, no slice load
        clear_counts();
        expect_job(48'd0, 1'b1);
        start_job(8'd0);
        chk("t3_done_next", 64'(done), 64'd1);
        @(posedge clk); #1;
        chk("t3_ce_ab_none", 64'(ce_ab_cyc), 64'd0);
        chk("t3_busy_after", 64'(busy), 64'd0);

        // T4: job A (2*3 + 3*2 = 12) then job B (2*3 = 6) one idle cycle apart
        va[0] = 18'sd2; vb[0] = 18'sd3;
        va[1] = 18'sd3; vb[1] = 18'sd2;
        expect_job(48'd12, 1'b1);
        start_job(8'd2);
        send_beats(2, 0);
        wait_done();
        va[0] = 18'sd2; vb[0] = 18'sd3;
        expect_job(48'd6, 1'b1);
        start_job(8'd1);
        chk("t4_busy_b", 64'(busy), 64'd1);
        send_beats(1, 0);
        wait_done();
        @(posedge clk); #1;

        // T5: reset after 2 of 5 beats, then (9,9) -> 81
        for (int i = 0; i < 5; i++) begin
            va[i] = 18'sd1 + 18'(i); vb[i] = 18'sd1;
        end
        start_job(8'd5);
        send_beats(2, 0);
        rst = 1'b1;
        #1;
        chk("t5_rstp_during_rst", 64'(dsp_rstp), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_s_ready", 64'(s_ready), 64'd0);
        chk("t5_no_done", 64'(done), 64'd0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        va[0] = 18'sd9; vb[0] = 18'sd9;
        expect_job(48'd81, 1'b1);
        start_job(8'd1);
        send_beats(1, 0);
        wait_done();
        @(posedge clk); #1;

`ifdef DSP_MAC_ABORT_EN
        // T6: abort in DRAIN -> done without result_valid, result keeps 81
        for (int i = 0; i < 3; i++) begin
            va[i] = 18'sd5; vb[i] = 18'sd5;
        end
        start_job(8'd3);
        send_beats(3, 0);
        abort = 1'b1;
        expect_job(48'd81, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_rstp_pulse", 64'(dsp_rstp), 64'd1);
        @(posedge clk); #1;
        chk("t6_rstp_end", 64'(dsp_rstp), 64'd0);
        chk("t6_done_end", 64'(done), 64'd0);
`endif

        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("sb_drained", 64'(exp_res_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
